// File: rtl/prog_loader.sv
// Program loader: streams 16 bytes from a host into a 16 x 8 program memory, then releases the core.
// Define PROG_LOADER_CKSUM_EN to require a 17th two's-complement checksum byte before release.
module prog_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] pc,
  output logic [7:0] instr,
  output logic       core_rst_n,
  output logic       load_done,
  output logic       load_err
);

`ifdef PROG_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCheck = 3'd2,
    StRun   = 3'd3,
    StErr   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StRun  = 3'd3
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       mem_we;
  logic [7:0] mem_q [16];

`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] sum_next;

  assign sum_next = sum_q + in_data;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mem_we     = 1'b0;
    in_ready   = 1'b0;
    core_rst_n = 1'b0;
    load_done  = 1'b0;
    load_err   = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
    sum_d      = sum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          count_d = 4'd0;
`ifdef PROG_LOADER_CKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we = 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
          sum_d  = sum_next;
`endif
          // Count saturates at 15 so no 17th write can land in the array.
          if (count_q == 4'd15) begin
`ifdef PROG_LOADER_CKSUM_EN
            state_d = StCheck;
`else
            state_d = StRun;
`endif
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      StCheck: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (sum_next == 8'd0) ? StRun : StErr;
        end
      end
      StErr: begin
        load_err = 1'b1;
        if (start) begin
          state_d = StLoad;
          count_d = 4'd0;
          sum_d   = 8'd0;
        end
      end
`endif
      StRun: begin
        core_rst_n = 1'b1;
        load_done  = 1'b1;
        if (start) begin
          state_d = StLoad;
          count_d = 4'd0;
`ifdef PROG_LOADER_CKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= 4'd0;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q   <= 8'd0;
`endif
      // Reset fills memory with HLT so a half-loaded program can never run.
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'hFF;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q   <= sum_d;
`endif
      if (mem_we) begin
        mem_q[count_q] <= in_data;
      end
    end
  end

  assign instr = (state_q == StRun) ? mem_q[pc] : 8'h00;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader; covers both builds via PROG_LOADER_CKSUM_EN.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] pc;
  logic [7:0] instr;
  logic       core_rst_n;
  logic       load_done;
  logic       load_err;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  logic [7:0] prog      [16];
  logic [7:0] model_mem [16];
  logic [7:0] exp_q [$];

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pc         (pc),
    .instr      (instr),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && in_valid && in_ready) xfers <= xfers + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic rdy, input logic crn,
                               input logic done, input logic err);
    check({tag, "_in_ready"}, in_ready, rdy);
    check({tag, "_core_rst_n"}, core_rst_n, crn);
    check({tag, "_load_done"}, load_done, done);
    check({tag, "_load_err"}, load_err, err);
  endtask

  // Presents one byte and holds it until accepted; returns 1 time unit after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h5A;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Streams prog[] (plus checksum byte in the checksum build); optional toggling/stalls.
  task automatic load_prog(input bit toggle, input bit bad_ck, input bit start_mid);
    logic [7:0] sum = 8'd0;
    int x0 = xfers;
    int s0 = $urandom_range(0, 4);
    int s1 = $urandom_range(5, 9);
    int s2 = $urandom_range(10, 15);
    for (int i = 0; i < 16; i++) begin
      if (toggle) begin
        idle_cycles(1);
        if (i == s0 || i == s1 || i == s2) idle_cycles($urandom_range(1, 3));
      end
      if (start_mid && i == 6) pulse_start();
      send_byte(prog[i]);
      model_mem[i] = prog[i];
      sum = sum + prog[i];
    end
`ifdef PROG_LOADER_CKSUM_EN
    send_byte(bad_ck ? 8'(8'd1 - sum) : 8'(8'd0 - sum));
    check("xfer_count", xfers - x0, 17);
`else
    check("xfer_count", xfers - x0, 16);
`endif
  endtask

  task automatic readback(input string tag, input bit running);
    for (int i = 0; i < 16; i++) exp_q.push_back(running ? model_mem[i] : 8'h00);
    for (int i = 0; i < 16; i++) begin
      pc = 4'(i);
      #1;
      check({tag, "_instr"}, instr, exp_q.pop_front());
    end
  endtask

  task automatic set_req028();
    logic [7:0] head [5];
    head[0] = 8'h91; head[1] = 8'h61; head[2] = 8'h15; head[3] = 8'h16; head[4] = 8'hA7;
    for (int i = 0; i < 16; i++) prog[i] = (i < 5) ? head[i] : 8'hFF;
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    pc       = 4'd0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'hFF;

    // Reset state
    #12;
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_instr", instr, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);
    check_outputs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic load, release the cycle after the final byte
    set_req028();
    pulse_start();
    check_outputs("load", 1'b1, 1'b0, 1'b0, 1'b0);
    load_prog(1'b0, 1'b0, 1'b0);
    check_outputs("run1", 1'b0, 1'b1, 1'b1, 1'b0);
    pc = 4'd2; #1; check("pc2_instr", instr, 8'h15);
    pc = 4'd4; #1; check("pc4_instr", instr, 8'hA7);
    readback("run1", 1'b1);

`ifdef PROG_LOADER_CKSUM_EN
    // Corrupted checksum byte (0x48) lands in ERR
    pulse_start();
    load_prog(1'b0, 1'b1, 1'b0);
    check_outputs("err", 1'b0, 1'b0, 1'b0, 1'b1);
    readback("err", 1'b0);
    pulse_start();
    check_outputs("err_reload", 1'b1, 1'b0, 1'b0, 1'b0);
    load_prog(1'b0, 1'b0, 1'b0);
    check_outputs("err_recover", 1'b0, 1'b1, 1'b1, 1'b0);
`endif

    // Reload from RUN with in_valid toggling, random stalls and an ignored start mid-load
    @(posedge clk);
    #1;
    pulse_start();
    check_outputs("reload", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    load_prog(1'b1, 1'b0, 1'b1);
    check_outputs("run2", 1'b0, 1'b1, 1'b1, 1'b0);
    readback("run2", 1'b1);

    // Reset after 7 accepted bytes throws the partial program away
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + i));
    rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'hFF;
    check_outputs("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_instr", instr, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);
    check_outputs("midrst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) prog[i] = 8'(8'hC0 + i);
    pulse_start();
    load_prog(1'b0, 1'b0, 1'b0);
    check_outputs("run3", 1'b0, 1'b1, 1'b1, 1'b0);
    readback("run3", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
